mem_access: RTL and testbench

- Memory-access stage directly downstream of the execute stage. It consumes the execute stage's pipeline outputs: actions, DMEM addresses, store word, result and result register index.
- Performs loads and stores over a req/ack DMEM handshake with variable latency.
- Stalls the upstream pipeline while an access is outstanding.
- Delivers the write-back tuple (enable, register index, result) to the register file.

---
 rtl/swt16_pkg.sv | 25 ++
 rtl/dmem_req_ctrl.sv | 95 +++++++++
 rtl/mem_access.sv | 136 +++++++++++++
 tb/tb_mem_access.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swt16_pkg.sv
`default_nettype none
// ============================================================================
// Module : swt16_pkg
// Brief  : Shared widths, memory-stage FSM states and PC step for the core.
// Rev    : 1.0
// ============================================================================
package swt16_pkg;

    localparam int C_DMEM_ADDR_WIDTH = 12;
    localparam int C_DMEM_WORD_WIDTH = 16;
    localparam int C_IALU_WORD_WIDTH = 16;
    localparam int C_PMEM_WORD_WIDTH = 16;
    localparam int C_PC_WIDTH        = 12;
    localparam int C_REG_IDX_WIDTH   = 4;
    localparam int C_TIMEOUT_CYCLES  = 15;

    localparam logic [C_PC_WIDTH-1:0] PC_INCREMENT = 12'd1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dmem_req_ctrl
// Brief  : DMEM req/ack FSM, stall generation and optional access timeout
//          (MEM_ACCESS_TIMEOUT_EN).
// Rev    : 1.0
// ============================================================================
module dmem_req_ctrl
    import swt16_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = C_DMEM_ADDR_WIDTH,
    parameter int DMEM_WORD_WIDTH = C_DMEM_WORD_WIDTH,
    parameter int TIMEOUT_CYCLES  = C_TIMEOUT_CYCLES
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       load_i,
    input  logic                       store_i,
    input  logic [DMEM_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [DMEM_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DMEM_WORD_WIDTH-1:0] wr_word_i,
    input  logic                       dmem_ack_i,
    output logic                       dmem_req_o,
    output logic                       dmem_we_o,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [DMEM_WORD_WIDTH-1:0] dmem_wr_word_o,
    output logic                       stall_o,
    output logic                       abort_o,
    output logic                       mem_error_o
);

    mem_state_e                 state_q;
    logic                       req_q;
    logic                       we_q;
    logic [DMEM_ADDR_WIDTH-1:0] addr_q;
    logic [DMEM_WORD_WIDTH-1:0] word_q;
    logic                       w_timeout;
    logic                       w_mem_op;

    assign w_mem_op = load_i | store_i;
    assign stall_o  = (state_q == ACCESS) && !dmem_ack_i && !w_timeout;
    assign abort_o  = w_timeout;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 15) ? $clog2(TIMEOUT_CYCLES + 1) : 4;

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Abort in the last permitted ACCESS cycle so req is high exactly TIMEOUT_CYCLES cycles.
    assign w_timeout = (state_q == ACCESS) && !dmem_ack_i
                       && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= stall_o ? cnt_q + 1'b1 : '0;
            err_q <= w_timeout;
        end
    end

    assign mem_error_o = err_q;
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign mem_error_o      = 1'b0;
`endif

    // Outputs are registered alongside the state so address/data cannot glitch under req.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            word_q  <= '0;
        end else if (!stall_o) begin
            state_q <= w_mem_op ? ACCESS : IDLE;
            req_q   <= w_mem_op;
            we_q    <= store_i;
            addr_q  <= store_i ? wr_addr_i : (load_i ? rd_addr_i : '0);
            word_q  <= store_i ? wr_word_i : '0;
        end
    end

    assign dmem_req_o     = req_q;
    assign dmem_we_o      = we_q;
    assign dmem_addr_o    = addr_q;
    assign dmem_wr_word_o = word_q;

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module : mem_access
// Brief  : Memory-access pipeline stage: DMEM loads/stores, upstream stall and
//          write-back tuple. Optional timeout via MEM_ACCESS_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
module mem_access
    import swt16_pkg::*;
#(
    parameter int DMEM_ADDR_WIDTH = C_DMEM_ADDR_WIDTH,
    parameter int DMEM_WORD_WIDTH = C_DMEM_WORD_WIDTH,
    parameter int IALU_WORD_WIDTH = C_IALU_WORD_WIDTH,
    parameter int PMEM_WORD_WIDTH = C_PMEM_WORD_WIDTH,
    parameter int PC_WIDTH        = C_PC_WIDTH,
    parameter int REG_IDX_WIDTH   = C_REG_IDX_WIDTH,
    parameter int TIMEOUT_CYCLES  = C_TIMEOUT_CYCLES
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic                       in_act_write_res_to_reg,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
    input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [IALU_WORD_WIDTH-1:0] in_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic                       in_dmem_ack,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_rd_word,
    output logic                       out_dmem_req,
    output logic                       out_dmem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_dmem_wr_word,
    output logic                       out_stall,
    output logic                       out_act_write_res_to_reg,
    output logic [IALU_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic                       out_mem_error
);

    // Address/store-data half of the stage register lives in dmem_req_ctrl.
    typedef struct packed {
        logic                       load;
        logic                       store;
        logic                       write;
        logic [PMEM_WORD_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]        pc;
        logic [IALU_WORD_WIDTH-1:0] res;
        logic [REG_IDX_WIDTH-1:0]   idx;
    } stage_t;

    stage_t                     s_q;
    stage_t                     s_d;
    logic                       w_stall;
    logic                       w_abort;
    logic [IALU_WORD_WIDTH-1:0] w_res_d;
    logic                       wb_en_q;
    logic [IALU_WORD_WIDTH-1:0] wb_res_q;
    logic [REG_IDX_WIDTH-1:0]   wb_idx_q;
    logic [PMEM_WORD_WIDTH-1:0] wb_instr_q;
    logic [PC_WIDTH-1:0]        wb_pc_q;

    dmem_req_ctrl #(
        .DMEM_ADDR_WIDTH (DMEM_ADDR_WIDTH),
        .DMEM_WORD_WIDTH (DMEM_WORD_WIDTH),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) u_dmem_req_ctrl (
        .clock          (clock),
        .reset          (reset),
        .load_i         (in_act_load_dmem),
        .store_i        (in_act_store_dmem),
        .rd_addr_i      (in_dmem_rd_addr),
        .wr_addr_i      (in_dmem_wr_addr),
        .wr_word_i      (in_dmem_wr_word),
        .dmem_ack_i     (in_dmem_ack),
        .dmem_req_o     (out_dmem_req),
        .dmem_we_o      (out_dmem_we),
        .dmem_addr_o    (out_dmem_addr),
        .dmem_wr_word_o (out_dmem_wr_word),
        .stall_o        (w_stall),
        .abort_o        (w_abort),
        .mem_error_o    (out_mem_error)
    );

    always_comb begin
        s_d.load  = in_act_load_dmem;
        s_d.store = in_act_store_dmem;
        s_d.write = in_act_write_res_to_reg;
        s_d.instr = in_instr;
        s_d.pc    = in_pc;
        s_d.res   = in_res;
        s_d.idx   = in_res_reg_idx;
    end

    // Store wins when both flags are set, so only a pure load takes DMEM data.
    always_comb begin
        w_res_d = s_q.res;
        if (s_q.load && !s_q.store) begin
            w_res_d = w_abort ? '0 : IALU_WORD_WIDTH'(in_dmem_rd_word);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_q        <= '0;
            wb_en_q    <= 1'b0;
            wb_res_q   <= '0;
            wb_idx_q   <= '0;
            wb_instr_q <= '0;
            wb_pc_q    <= '0;
        end else if (w_stall) begin
            wb_en_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            wb_en_q    <= s_q.write && !(w_abort && s_q.store);
            wb_res_q   <= w_res_d;
            wb_idx_q   <= s_q.idx;
            wb_instr_q <= s_q.instr;
            wb_pc_q    <= s_q.pc;
        end
    end

    assign out_stall                = w_stall;
    assign out_act_write_res_to_reg = wb_en_q;
    assign out_res                  = wb_res_q;
    assign out_res_reg_idx          = wb_idx_q;
    assign out_instr                = wb_instr_q;
    assign out_pc                   = wb_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_access
// Brief  : Scoreboard bench for mem_access (timeout scenario under
//          MEM_ACCESS_TIMEOUT_EN).
// Rev    : 1.0
// ============================================================================
module tb_mem_access;

    logic        clock;
    logic        reset;
    logic        in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg;
    logic [11:0] in_dmem_rd_addr, in_dmem_wr_addr;
    logic [15:0] in_dmem_wr_word, in_instr, in_res, in_dmem_rd_word;
    logic [11:0] in_pc;
    logic [3:0]  in_res_reg_idx;
    logic        in_dmem_ack;
    logic        out_dmem_req, out_dmem_we, out_stall, out_act_write_res_to_reg, out_mem_error;
    logic [11:0] out_dmem_addr, out_pc;
    logic [15:0] out_dmem_wr_word, out_res, out_instr;
    logic [3:0]  out_res_reg_idx;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] res;
        logic [15:0] instr;
        logic [11:0] pc;
    } wb_t;

    wb_t sb[$];
    wb_t exp_wb;
    int  errors = 0;
    int  checks = 0;

    mem_access dut (
        .clock                    (clock),
        .reset                    (reset),
        .in_act_load_dmem         (in_act_load_dmem),
        .in_act_store_dmem        (in_act_store_dmem),
        .in_act_write_res_to_reg  (in_act_write_res_to_reg),
        .in_dmem_rd_addr          (in_dmem_rd_addr),
        .in_dmem_wr_addr          (in_dmem_wr_addr),
        .in_dmem_wr_word          (in_dmem_wr_word),
        .in_instr                 (in_instr),
        .in_pc                    (in_pc),
        .in_res                   (in_res),
        .in_res_reg_idx           (in_res_reg_idx),
        .in_dmem_ack              (in_dmem_ack),
        .in_dmem_rd_word          (in_dmem_rd_word),
        .out_dmem_req             (out_dmem_req),
        .out_dmem_we              (out_dmem_we),
        .out_dmem_addr            (out_dmem_addr),
        .out_dmem_wr_word         (out_dmem_wr_word),
        .out_stall                (out_stall),
        .out_act_write_res_to_reg (out_act_write_res_to_reg),
        .out_res                  (out_res),
        .out_res_reg_idx          (out_res_reg_idx),
        .out_instr                (out_instr),
        .out_pc                   (out_pc),
        .out_mem_error            (out_mem_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic drive_op(input logic ld, input logic st, input logic wr,
                            input logic [11:0] ra, input logic [11:0] wa, input logic [15:0] ww,
                            input logic [15:0] res, input logic [3:0] idx,
                            input logic [15:0] instr, input logic [11:0] pc);
        in_act_load_dmem        = ld;
        in_act_store_dmem       = st;
        in_act_write_res_to_reg = wr;
        in_dmem_rd_addr         = ra;
        in_dmem_wr_addr         = wa;
        in_dmem_wr_word         = ww;
        in_res                  = res;
        in_res_reg_idx          = idx;
        in_instr                = instr;
        in_pc                   = pc;
    endtask

    task automatic drive_nop();
        drive_op(1'b0, 1'b0, 1'b0, 12'h0, 12'h0, 16'h0, 16'h0, 4'h0, 16'h0, 12'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_dmem_ack = 1'b0;
        in_dmem_rd_word = 16'h0;
        drive_nop();
        repeat (3) @(negedge clock);
        checks++;
        if ({out_dmem_req, out_dmem_we, out_dmem_addr, out_dmem_wr_word} !== 30'h0) begin
            errors++;
            $display("FAIL reset_dmem: got req=%b we=%b addr=%h word=%h, want all 0",
                     out_dmem_req, out_dmem_we, out_dmem_addr, out_dmem_wr_word);
        end
        checks++;
        if ({out_stall, out_mem_error, out_act_write_res_to_reg} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got stall=%b err=%b wb_en=%b, want 0 0 0",
                     out_stall, out_mem_error, out_act_write_res_to_reg);
        end
        checks++;
        if ({out_res_reg_idx, out_res, out_instr, out_pc} !== 48'h0) begin
            errors++;
            $display("FAIL reset_wb: got idx=%h res=%h instr=%h pc=%h, want 0",
                     out_res_reg_idx, out_res, out_instr, out_pc);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_alu();
        drive_op(1'b0, 1'b0, 1'b1, 12'h0, 12'h0, 16'h0, 16'h1234, 4'd3, 16'hC0DE, 12'h100);
        sb.push_back('{idx: 4'd3, res: 16'h1234, instr: 16'hC0DE, pc: 12'h100});
        @(negedge clock);
        drive_nop();
        checks++;
        if ({out_dmem_req, out_stall, out_act_write_res_to_reg} !== 3'b000) begin
            errors++;
            $display("FAIL alu_edge1: got req=%b stall=%b wb_en=%b, want 0 0 0",
                     out_dmem_req, out_stall, out_act_write_res_to_reg);
        end
        @(negedge clock);
        checks++;
        if (out_act_write_res_to_reg !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL alu_wb_en: got en=%b queued=%0d, want en=1", out_act_write_res_to_reg, sb.size());
        end else begin
            exp_wb = sb.pop_front();
            checks++;
            if ({out_res_reg_idx, out_res, out_instr, out_pc} !== exp_wb) begin
                errors++;
                $display("FAIL alu_wb: got %h want %h", {out_res_reg_idx, out_res, out_instr, out_pc}, exp_wb);
            end
        end
        checks++;
        if ({out_dmem_req, out_stall} !== 2'b00) begin
            errors++;
            $display("FAIL alu_no_req: got req=%b stall=%b, want 0 0", out_dmem_req, out_stall);
        end
    endtask

    task automatic test_load();
        drive_op(1'b1, 1'b0, 1'b1, 12'h010, 12'h0, 16'h0, 16'h1111, 4'd5, 16'h1A05, 12'h101);
        sb.push_back('{idx: 4'd5, res: 16'hBEEF, instr: 16'h1A05, pc: 12'h101});
        @(negedge clock);
        checks++;
        if ({out_dmem_req, out_dmem_we, out_dmem_addr, out_dmem_wr_word} !== {1'b1, 1'b0, 12'h010, 16'h0}) begin
            errors++;
            $display("FAIL load_req: got req=%b we=%b addr=%h word=%h, want 1 0 010 0000",
                     out_dmem_req, out_dmem_we, out_dmem_addr, out_dmem_wr_word);
        end
        in_dmem_ack = 1'b1;
        in_dmem_rd_word = 16'hBEEF;
        drive_nop();
        #1;
        checks++;
        if (out_stall !== 1'b0) begin
            errors++;
            $display("FAIL load_stall: got %b want 0", out_stall);
        end
        @(negedge clock);
        in_dmem_ack = 1'b0;
        checks++;
        if (out_dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL load_req_drop: got %b want 0", out_dmem_req);
        end
        checks++;
        if (out_act_write_res_to_reg !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL load_wb_en: got en=%b queued=%0d, want en=1", out_act_write_res_to_reg, sb.size());
        end else begin
            exp_wb = sb.pop_front();
            checks++;
            if ({out_res_reg_idx, out_res, out_instr, out_pc} !== exp_wb) begin
                errors++;
                $display("FAIL load_wb: got %h want %h", {out_res_reg_idx, out_res, out_instr, out_pc}, exp_wb);
            end
        end
    endtask

    task automatic test_store();
        drive_op(1'b0, 1'b1, 1'b0, 12'h0, 12'h020, 16'h5A5A, 16'h0, 4'd0, 16'h2B00, 12'h102);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if ({out_dmem_req, out_dmem_we, out_dmem_addr, out_dmem_wr_word} !== {1'b1, 1'b1, 12'h020, 16'h5A5A}) begin
                errors++;
                $display("FAIL store_req[%0d]: got req=%b we=%b addr=%h word=%h, want 1 1 020 5a5a",
                         k, out_dmem_req, out_dmem_we, out_dmem_addr, out_dmem_wr_word);
            end
            checks++;
            if (out_act_write_res_to_reg !== 1'b0) begin
                errors++;
                $display("FAIL store_wb_bubble[%0d]: got en=%b want 0", k, out_act_write_res_to_reg);
            end
            if (k == 0) begin
                drive_op(1'b0, 1'b0, 1'b1, 12'h0, 12'h0, 16'h0, 16'h7777, 4'd7, 16'h3C07, 12'h103);
                sb.push_back('{idx: 4'd7, res: 16'h7777, instr: 16'h3C07, pc: 12'h103});
            end
            in_dmem_ack = (k == 3);
            #1;
            checks++;
            if (out_stall !== (k < 3)) begin
                errors++;
                $display("FAIL store_stall[%0d]: got %b want %b", k, out_stall, (k < 3));
            end
        end
        @(negedge clock);
        in_dmem_ack = 1'b0;
        drive_nop();
        checks++;
        if ({out_dmem_req, out_act_write_res_to_reg} !== 2'b00) begin
            errors++;
            $display("FAIL store_done: got req=%b wb_en=%b, want 0 0", out_dmem_req, out_act_write_res_to_reg);
        end
        @(negedge clock);
        checks++;
        if (out_act_write_res_to_reg !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL held_wb_en: got en=%b queued=%0d, want en=1", out_act_write_res_to_reg, sb.size());
        end else begin
            exp_wb = sb.pop_front();
            checks++;
            if ({out_res_reg_idx, out_res, out_instr, out_pc} !== exp_wb) begin
                errors++;
                $display("FAIL held_wb: got %h want %h", {out_res_reg_idx, out_res, out_instr, out_pc}, exp_wb);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive_op(1'b1, 1'b0, 1'b1, 12'h010, 12'h0, 16'h0, 16'h0, 4'd2, 16'h4D02, 12'h104);
        sb.push_back('{idx: 4'd2, res: 16'hA5A5, instr: 16'h4D02, pc: 12'h104});
        @(negedge clock);
        checks++;
        if ({out_dmem_req, out_dmem_we, out_dmem_addr} !== {1'b1, 1'b0, 12'h010}) begin
            errors++;
            $display("FAIL b2b_first: got req=%b we=%b addr=%h, want 1 0 010", out_dmem_req, out_dmem_we, out_dmem_addr);
        end
        in_dmem_ack = 1'b1;
        in_dmem_rd_word = 16'hA5A5;
        drive_op(1'b0, 1'b1, 1'b0, 12'h0, 12'h020, 16'h1357, 16'h0, 4'd0, 16'h5E00, 12'h105);
        @(negedge clock);
        checks++;
        if ({out_dmem_req, out_dmem_we, out_dmem_addr, out_dmem_wr_word} !== {1'b1, 1'b1, 12'h020, 16'h1357}) begin
            errors++;
            $display("FAIL b2b_second: got req=%b we=%b addr=%h word=%h, want 1 1 020 1357",
                     out_dmem_req, out_dmem_we, out_dmem_addr, out_dmem_wr_word);
        end
        checks++;
        if (out_act_write_res_to_reg !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL b2b_wb_en: got en=%b queued=%0d, want en=1", out_act_write_res_to_reg, sb.size());
        end else begin
            exp_wb = sb.pop_front();
            checks++;
            if ({out_res_reg_idx, out_res, out_instr, out_pc} !== exp_wb) begin
                errors++;
                $display("FAIL b2b_wb: got %h want %h", {out_res_reg_idx, out_res, out_instr, out_pc}, exp_wb);
            end
        end
        drive_nop();
        @(negedge clock);
        in_dmem_ack = 1'b0;
        checks++;
        if ({out_dmem_req, out_act_write_res_to_reg} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_end: got req=%b wb_en=%b, want 0 0", out_dmem_req, out_act_write_res_to_reg);
        end
    endtask

    task automatic test_reset_in_access();
        drive_op(1'b1, 1'b0, 1'b1, 12'h030, 12'h0, 16'h0, 16'h0, 4'd9, 16'h6F09, 12'h106);
        @(negedge clock);
        drive_nop();
        @(negedge clock);
        checks++;
        if ({out_dmem_req, out_stall} !== 2'b11) begin
            errors++;
            $display("FAIL rst_acc_pre: got req=%b stall=%b, want 1 1", out_dmem_req, out_stall);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({out_dmem_req, out_dmem_addr, out_stall, out_act_write_res_to_reg, out_res, out_res_reg_idx} !== 35'h0) begin
            errors++;
            $display("FAIL rst_acc_drop: got req=%b addr=%h stall=%b wb_en=%b res=%h idx=%h, want 0",
                     out_dmem_req, out_dmem_addr, out_stall, out_act_write_res_to_reg, out_res, out_res_reg_idx);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        in_dmem_ack = 1'b1;
        in_dmem_rd_word = 16'hDEAD;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({out_dmem_req, out_stall, out_act_write_res_to_reg} !== 3'b000) begin
                errors++;
                $display("FAIL rst_acc_ignore[%0d]: got req=%b stall=%b wb_en=%b, want 0 0 0",
                         k, out_dmem_req, out_stall, out_act_write_res_to_reg);
            end
            @(negedge clock);
        end
        in_dmem_ack = 1'b0;
    endtask

    task automatic test_timeout();
        drive_op(1'b1, 1'b0, 1'b1, 12'h040, 12'h0, 16'h0, 16'h9999, 4'd4, 16'h7004, 12'h107);
`ifdef MEM_ACCESS_TIMEOUT_EN
        sb.push_back('{idx: 4'd4, res: 16'h0000, instr: 16'h7004, pc: 12'h107});
        for (int k = 0; k < 15; k++) begin
            @(negedge clock);
            if (k == 0) drive_nop();
            checks++;
            if ({out_dmem_req, out_mem_error, out_stall} !== {1'b1, 1'b0, (k < 14)}) begin
                errors++;
                $display("FAIL tmo_access[%0d]: got req=%b err=%b stall=%b, want 1 0 %b",
                         k, out_dmem_req, out_mem_error, out_stall, (k < 14));
            end
        end
        @(negedge clock);
        checks++;
        if ({out_dmem_req, out_mem_error, out_stall} !== 3'b010) begin
            errors++;
            $display("FAIL tmo_abort: got req=%b err=%b stall=%b, want 0 1 0", out_dmem_req, out_mem_error, out_stall);
        end
`else
        sb.push_back('{idx: 4'd4, res: 16'h4242, instr: 16'h7004, pc: 12'h107});
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (k == 0) drive_nop();
            checks++;
            if ({out_dmem_req, out_mem_error, out_stall} !== 3'b101) begin
                errors++;
                $display("FAIL wait_access[%0d]: got req=%b err=%b stall=%b, want 1 0 1",
                         k, out_dmem_req, out_mem_error, out_stall);
            end
        end
        in_dmem_ack = 1'b1;
        in_dmem_rd_word = 16'h4242;
        @(negedge clock);
        in_dmem_ack = 1'b0;
        checks++;
        if ({out_dmem_req, out_mem_error} !== 2'b00) begin
            errors++;
            $display("FAIL wait_done: got req=%b err=%b, want 0 0", out_dmem_req, out_mem_error);
        end
`endif
        checks++;
        if (out_act_write_res_to_reg !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL tmo_wb_en: got en=%b queued=%0d, want en=1", out_act_write_res_to_reg, sb.size());
        end else begin
            exp_wb = sb.pop_front();
            checks++;
            if ({out_res_reg_idx, out_res, out_instr, out_pc} !== exp_wb) begin
                errors++;
                $display("FAIL tmo_wb: got %h want %h", {out_res_reg_idx, out_res, out_instr, out_pc}, exp_wb);
            end
        end
        @(negedge clock);
        checks++;
        if ({out_mem_error, out_act_write_res_to_reg} !== 2'b00) begin
            errors++;
            $display("FAIL tmo_after: got err=%b wb_en=%b, want 0 0", out_mem_error, out_act_write_res_to_reg);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_in_access();
        test_timeout();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
